// File: rtl/mul_pkg.sv
// mul_pkg: shared definitions for the iterative multiplier.
//   - op-select bit indices into the one-hot mul_op field
//   - FSM state encoding
//   - operand, product and accumulator-high widths
//   - sel_result(): picks the architectural 32-bit half of the product
package mul_pkg;

  localparam int MUL_OP_W  = 0;
  localparam int MUL_OP_H  = 1;
  localparam int MUL_OP_HU = 2;

  localparam int OPND_W = 33;
  localparam int PROD_W = 66;
  // High accumulator half: a 33-bit multiplicand times a Booth digit
  // of up to 2, plus a running partial sum, needs a few guard bits.
  localparam int HI_W   = 36;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_DONE = 2'd2
  } state_t;

  // mul_op == 0 yields 0. A non-one-hot op ORs both halves together.
  function automatic logic [31:0] sel_result(input logic [2:0]  op,
                                             input logic [63:0] prod);
    return ({32{op[MUL_OP_W]}} & prod[31:0]) |
           ({32{op[MUL_OP_H] | op[MUL_OP_HU]}} & prod[63:32]);
  endfunction

endpackage

// File: rtl/mul_booth_step.sv
// mul_booth_step: one combinational Booth iteration.
// The accumulator layout is {hi[HI_W], multiplier[YW], y_prev}.
// Each step forms a partial product (0, +/-M, +/-2M) from the digit bits,
// adds it to the high half, and arithmetic-shifts the whole accumulator
// right by ITER_BITS. This retires the consumed multiplier bits and
// moves the low product bits into the vacated positions.
//   acc    : current accumulator
//   mcand  : 33-bit sign/zero-extended multiplicand
//   digit  : Booth digit bits {y[i+ITER_BITS-1..i], y_prev}
//   acc_nx : accumulator after this iteration
module mul_booth_step
  import mul_pkg::*;
#(
  parameter int ITER_BITS = 2,
  parameter int ACC_W     = 71
) (
  input  logic signed [ACC_W-1:0]  acc,
  input  logic signed [OPND_W-1:0] mcand,
  input  logic        [ITER_BITS:0] digit,
  output logic signed [ACC_W-1:0]  acc_nx
);

  logic signed [HI_W-1:0] m1;
  logic signed [HI_W-1:0] m2;
  logic signed [HI_W-1:0] pp;
  logic signed [HI_W-1:0] sum;
  logic        [ACC_W-1:0] pre;

  assign m1 = {{(HI_W-OPND_W){mcand[OPND_W-1]}}, mcand};
  assign m2 = m1 <<< 1;

  generate
    if (ITER_BITS == 2) begin : g_radix4
      always_comb begin
        case (digit)
          3'b001, 3'b010: pp = m1;
          3'b011:         pp = m2;
          3'b100:         pp = -m2;
          3'b101, 3'b110: pp = -m1;
          default:        pp = '0;
        endcase
      end
    end else begin : g_radix2
      // digit = {y0, y_prev}: 01 -> +M, 10 -> -M
      always_comb begin
        case (digit[1:0])
          2'b01:   pp = m1;
          2'b10:   pp = -m1;
          default: pp = '0;
        endcase
      end
    end
  endgenerate

  assign sum    = $signed(acc[ACC_W-1 -: HI_W]) + pp;
  assign pre    = {sum, acc[ACC_W-HI_W-1:0]};
  assign acc_nx = $signed(pre) >>> ITER_BITS;

endmodule

// File: rtl/mul_iter_ctrl.sv
// mul_iter_ctrl: fixed-latency iterative multiplier for mul.w / mulh.w /
// mulh.wu. It has a valid/ready issue port, a valid/ready result port,
// and a synchronous flush.
//   clk, reset             : clock, async active-high reset
//   flush                  : cancel any in-flight or pending op
//   in_valid / in_ready    : issue handshake
//   mul_op                 : one-hot {mulh.wu, mulh.w, mul.w}
//   mul_src1 / mul_src2    : multiplicand / multiplier
//   out_valid / out_ready  : result handshake
//   mul_result             : selected product half, held until consumed
//   busy                   : high while in CALC or DONE
module mul_iter_ctrl
  import mul_pkg::*;
#(
  parameter int ITER_BITS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  mul_op,
  input  logic [31:0] mul_src1,
  input  logic [31:0] mul_src2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] mul_result,
  output logic        busy
);

  localparam int N_ITER = (ITER_BITS == 1) ? 33 : 17;
  // Multiplier field width: exactly the bits consumed by N_ITER digits.
  localparam int YW     = ITER_BITS * N_ITER;
  localparam int ACC_W  = HI_W + YW + 1;
  localparam logic [5:0] CNT_INIT = 6'(N_ITER);

  state_t state;
  state_t state_nx;
  logic   accept;

  logic        [5:0]        cnt;
  logic        [2:0]        op_q;
  logic signed [OPND_W-1:0] mcand;
  logic signed [ACC_W-1:0]  acc;
  logic signed [ACC_W-1:0]  acc_nx;

  logic              s1_ext;
  logic              s2_ext;
  logic [YW-1:0]     y_ext;

  // Only mulh.w treats its operands as signed.
  assign s1_ext = mul_op[MUL_OP_H] & mul_src1[31];
  assign s2_ext = mul_op[MUL_OP_H] & mul_src2[31];
  assign y_ext  = {{(YW-32){s2_ext}}, mul_src2};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    in_ready = !flush && ((state == S_IDLE) || ((state == S_DONE) && out_ready));
    accept   = in_valid && in_ready;
    case (state)
      S_IDLE: if (accept) state_nx = S_CALC;
      S_CALC: if (cnt == 6'd1) state_nx = S_DONE;
      S_DONE: begin
        if (accept)         state_nx = S_CALC;
        else if (out_ready) state_nx = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
    if (flush) state_nx = S_IDLE;
  end

  assign out_valid = (state == S_DONE);
  assign busy      = (state != S_IDLE);

  mul_booth_step #(
    .ITER_BITS (ITER_BITS),
    .ACC_W     (ACC_W)
  ) u_step (
    .acc    (acc),
    .mcand  (mcand),
    .digit  (acc[ITER_BITS:0]),
    .acc_nx (acc_nx)
  );

  // After the final step, acc[PROD_W:1] holds the 66-bit product.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt        <= '0;
      op_q       <= '0;
      mcand      <= '0;
      acc        <= '0;
      mul_result <= '0;
    end else if (accept) begin
      cnt   <= CNT_INIT;
      op_q  <= mul_op;
      mcand <= {s1_ext, mul_src1};
      acc   <= {{HI_W{1'b0}}, y_ext, 1'b0};
    end else if (flush) begin
      cnt <= '0;
    end else if (state == S_CALC) begin
      acc <= acc_nx;
      cnt <= cnt - 6'd1;
      if (cnt == 6'd1) mul_result <= sel_result(op_q, acc_nx[64:1]);
    end
  end

endmodule
